// File: rtl/cpu16_pkg.sv
// Shared cpu16 control definitions: opcodes, ALUOp class codes, mux selects,
// main-control state encoding and the decoded control word.
package cpu16_pkg;

    localparam logic [3:0] OP_R0   = 4'b0000;
    localparam logic [3:0] OP_R1   = 4'b0001;
    localparam logic [3:0] OP_R2   = 4'b0010;
    localparam logic [3:0] OP_LW   = 4'b0100;
    localparam logic [3:0] OP_SW   = 4'b0101;
    localparam logic [3:0] OP_BEQ  = 4'b0110;
    localparam logic [3:0] OP_J    = 4'b0111;
    localparam logic [3:0] OP_ADDI = 4'b1001;
    localparam logic [3:0] OP_SUBI = 4'b1010;
    localparam logic [3:0] OP_SLTI = 4'b1011;
    localparam logic [3:0] OP_HALT = 4'b1111;

    // ALUOp class codes, also consumed by the ALU control decoder.
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_ITYPE = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_ONE  = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
        S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        OC_RTYPE, OC_MEM, OC_BRANCH, OC_JUMP, OC_ITYPE, OC_HALT, OC_ILLEGAL
    } op_class_t;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic       halted;
        logic       illegal_op;
    } ctrl_t;

    function automatic op_class_t classify(input logic [3:0] op);
        case (op)
            OP_R0, OP_R1, OP_R2:        return OC_RTYPE;
            OP_LW, OP_SW:               return OC_MEM;
            OP_BEQ:                     return OC_BRANCH;
            OP_J:                       return OC_JUMP;
            OP_ADDI, OP_SUBI, OP_SLTI:  return OC_ITYPE;
            OP_HALT:                    return OC_HALT;
            default:                    return OC_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/cpu16_main_ctrl_if.sv
// Controller <-> datapath bus. mem_ready is a one-cycle completion strobe for the
// access currently requested (FETCH, MEM_RD, MEM_WR); there is no other back-pressure.
interface cpu16_main_ctrl_if #(parameter int OPW = 4);
    logic [OPW-1:0] Opcode;
    logic           Zero;
    logic           mem_ready;
    logic [1:0]     ALUOp;
    logic           PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic           MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0]     ALUSrcB;
    logic [1:0]     PCSource;
    logic           halted;
    logic           illegal_op;

    modport master (
        input  Opcode, Zero, mem_ready,
        output ALUOp, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
               halted, illegal_op
    );

    modport slave (
        output Opcode, Zero, mem_ready,
        input  ALUOp, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
               halted, illegal_op
    );
endinterface

// File: rtl/cpu16_ctrl_decode.sv
// Combinational state -> control word decode. Only FETCH (mem_ready) and
// DECODE (illegal opcode flag) look at anything besides the state.
module cpu16_ctrl_decode
    import cpu16_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    input  logic [3:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_ONE;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b  = SRCB_BOFF;
                ctrl.alu_op     = ALU_ADD;
                ctrl.illegal_op = (classify(opcode) == OC_ILLEGAL);
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_RTYPE;
            end
            S_WB_R: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ITYPE;
            end
            S_WB_I:     ctrl.reg_write = 1'b1;
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_BRANCH: begin
                // PC update is qualified by Zero in the datapath, not here.
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_HALT:  ctrl.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu16_main_ctrl.sv
// Multi-cycle main control FSM: state register and next-state logic; the
// control word comes from cpu16_ctrl_decode.
module cpu16_main_ctrl
    import cpu16_pkg::*;
#(
    parameter int OPW = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    cpu16_main_ctrl_if.master     bus,
    output state_t                dbg_state
);

    state_t         state;
    logic           is_load;
    logic [OPW-1:0] opcode;
    op_class_t      cls;
    ctrl_t          ctrl;

    assign opcode    = bus.Opcode;
    assign cls       = classify(opcode);
    assign dbg_state = state;

    // Opcode is only valid in DECODE, so remember LW vs SW for MEM_ADDR.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            is_load <= 1'b0;
        end else begin
            case (state)
                S_IDLE:  state <= S_FETCH;
                S_FETCH: if (bus.mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    is_load <= (opcode == OP_LW);
                    case (cls)
                        OC_RTYPE:  state <= S_EXEC_R;
                        OC_MEM:    state <= S_MEM_ADDR;
                        OC_BRANCH: state <= S_BRANCH;
                        OC_JUMP:   state <= S_JUMP;
                        OC_ITYPE:  state <= S_EXEC_I;
                        OC_HALT:   state <= S_HALT;
                        default:   state <= S_FETCH;
                    endcase
                end
                S_EXEC_R:   state <= S_WB_R;
                S_WB_R:     state <= S_FETCH;
                S_EXEC_I:   state <= S_WB_I;
                S_WB_I:     state <= S_FETCH;
                S_MEM_ADDR: state <= is_load ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:   if (bus.mem_ready) state <= S_MEM_WB;
                S_MEM_WB:   state <= S_FETCH;
                S_MEM_WR:   if (bus.mem_ready) state <= S_FETCH;
                S_BRANCH:   state <= S_FETCH;
                S_JUMP:     state <= S_FETCH;
                S_HALT:     state <= S_HALT;
                default:    state <= S_IDLE;
            endcase
        end
    end

    cpu16_ctrl_decode u_decode (
        .state     (state),
        .mem_ready (bus.mem_ready),
        .opcode    (opcode),
        .ctrl      (ctrl)
    );

    assign bus.ALUOp       = ctrl.alu_op;
    assign bus.PCWrite     = ctrl.pc_write;
    assign bus.PCWriteCond = ctrl.pc_write_cond;
    assign bus.IorD        = ctrl.i_or_d;
    assign bus.MemRead     = ctrl.mem_read;
    assign bus.MemWrite    = ctrl.mem_write;
    assign bus.IRWrite     = ctrl.ir_write;
    assign bus.MemtoReg    = ctrl.mem_to_reg;
    assign bus.RegDst      = ctrl.reg_dst;
    assign bus.RegWrite    = ctrl.reg_write;
    assign bus.ALUSrcA     = ctrl.alu_src_a;
    assign bus.ALUSrcB     = ctrl.alu_src_b;
    assign bus.PCSource    = ctrl.pc_source;
    assign bus.halted      = ctrl.halted;
    assign bus.illegal_op  = ctrl.illegal_op;

endmodule

// File: tb/tb_cpu16_main_ctrl.sv
// Bench for cpu16_main_ctrl: per-cycle expected state + control word from a
// scoreboard queue, instruction vectors from a table, plus halt and reset-abort sequences.
module tb_cpu16_main_ctrl;
  import cpu16_pkg::*;

  localparam int W = 22;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  state_t dbg_state;

  cpu16_main_ctrl_if #(.OPW(4)) bus ();

  cpu16_main_ctrl #(.OPW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  logic         rdy_q[$];
  logic [3:0]   op_q[$];
  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0] op;
    int         fw;
    int         mw;
    int         cycles;
  } vec_t;
  vec_t vecs[17];

  function automatic logic [3:0] rnd4();
    return 4'($urandom_range(0, 15));
  endfunction

  function automatic logic rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic legal(logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b0111,
      4'b1001, 4'b1010, 4'b1011, 4'b1111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Expected {state, ALUOp, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
  // MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, halted, illegal_op}.
  function automatic logic [W-1:0] ew(state_t s, logic rdy, logic ill);
    logic [1:0] aluop, srcb, pcsrc;
    logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, srca, h, io;
    aluop = 2'b00; srcb = 2'b00; pcsrc = 2'b00;
    pcw = 0; pcwc = 0; iord = 0; mr = 0; mw = 0; irw = 0;
    m2r = 0; rd = 0; rw = 0; srca = 0; h = 0; io = 0;
    case (s)
      S_FETCH:    begin mr = 1; srcb = 2'b01; pcw = rdy; irw = rdy; end
      S_DECODE:   begin srcb = 2'b11; io = ill; end
      S_EXEC_R:   begin srca = 1; aluop = 2'b10; end
      S_WB_R:     begin rd = 1; rw = 1; end
      S_EXEC_I:   begin srca = 1; srcb = 2'b10; aluop = 2'b11; end
      S_WB_I:     rw = 1;
      S_MEM_ADDR: begin srca = 1; srcb = 2'b10; end
      S_MEM_RD:   begin mr = 1; iord = 1; end
      S_MEM_WB:   begin rw = 1; m2r = 1; end
      S_MEM_WR:   begin mw = 1; iord = 1; end
      S_BRANCH:   begin srca = 1; aluop = 2'b01; pcwc = 1; pcsrc = 2'b01; end
      S_JUMP:     begin pcw = 1; pcsrc = 2'b10; end
      S_HALT:     h = 1;
      default:    ;
    endcase
    return {s, aluop, pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, srca, srcb, pcsrc, h, io};
  endfunction

  function automatic logic [W-1:0] obs();
    return {dbg_state, bus.ALUOp, bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
            bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
            bus.ALUSrcB, bus.PCSource, bus.halted, bus.illegal_op};
  endfunction

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic push(state_t s, logic rdy, logic [3:0] op, logic ill);
    exp_q.push_back(ew(s, rdy, ill));
    rdy_q.push_back(rdy);
    op_q.push_back(op);
  endtask

  // Opcode is random outside DECODE so any sampling elsewhere shows up.
  task automatic push_instr(logic [3:0] op, int fw, int mw, int nhalt);
    for (int i = 0; i < fw; i++) push(S_FETCH, 1'b0, rnd4(), 1'b0);
    push(S_FETCH, 1'b1, rnd4(), 1'b0);
    push(S_DECODE, rnd1(), op, !legal(op));
    case (op)
      4'b0000, 4'b0001, 4'b0010: begin
        push(S_EXEC_R, rnd1(), rnd4(), 1'b0);
        push(S_WB_R, rnd1(), rnd4(), 1'b0);
      end
      4'b0100: begin
        push(S_MEM_ADDR, rnd1(), rnd4(), 1'b0);
        for (int i = 0; i < mw; i++) push(S_MEM_RD, 1'b0, rnd4(), 1'b0);
        push(S_MEM_RD, 1'b1, rnd4(), 1'b0);
        push(S_MEM_WB, rnd1(), rnd4(), 1'b0);
      end
      4'b0101: begin
        push(S_MEM_ADDR, rnd1(), rnd4(), 1'b0);
        for (int i = 0; i < mw; i++) push(S_MEM_WR, 1'b0, rnd4(), 1'b0);
        push(S_MEM_WR, 1'b1, rnd4(), 1'b0);
      end
      4'b0110: push(S_BRANCH, rnd1(), rnd4(), 1'b0);
      4'b0111: push(S_JUMP, rnd1(), rnd4(), 1'b0);
      4'b1001, 4'b1010, 4'b1011: begin
        push(S_EXEC_I, rnd1(), rnd4(), 1'b0);
        push(S_WB_I, rnd1(), rnd4(), 1'b0);
      end
      4'b1111: for (int i = 0; i < nhalt; i++) push(S_HALT, rnd1(), rnd4(), 1'b0);
      default: ;
    endcase
  endtask

  // Drains the scoreboard one cycle per entry; exp_cycles > 0 also checks the
  // DUT's FETCH-to-FETCH cycle count and that it is back in FETCH afterwards.
  task automatic run(string name, int exp_cycles);
    int cnt;
    logic seen_other, back;
    logic [W-1:0] e;
    cnt = 0; seen_other = 1'b0; back = 1'b0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      bus.mem_ready = rdy_q.pop_front();
      bus.Opcode    = op_q.pop_front();
      bus.Zero      = rnd1();
      #2;
      e = exp_q.pop_front();
      check(name, obs(), e);
      check({name, " excl"}, W'({bus.MemRead & bus.MemWrite, bus.RegWrite & bus.MemWrite}), '0);
      if (dbg_state == S_FETCH && seen_other) back = 1'b1;
      if (dbg_state != S_FETCH) seen_other = 1'b1;
      if (!back) cnt++;
    end
    if (exp_cycles > 0) begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      bus.Opcode    = rnd4();
      #2;
      tests++;
      if (dbg_state != S_FETCH || cnt != exp_cycles) begin
        fails++;
        $display("FAIL %s cycles: got %0d (state %0d) want %0d (state %0d)",
                 name, cnt, dbg_state, exp_cycles, S_FETCH);
      end
    end
  endtask

  task automatic do_reset(logic rdy);
    @(negedge clk);
    reset = 1'b1;
    bus.mem_ready = rdy;
    @(negedge clk);
    reset = 1'b0;
    bus.mem_ready = rnd1();
    bus.Opcode = rnd4();
    #2;
    check("reset_idle", obs(), ew(S_IDLE, 1'b0, 1'b0));
  endtask

  initial begin
    vecs[0]  = '{4'b0001, 0, 0, 4};
    vecs[1]  = '{4'b0000, 1, 0, 5};
    vecs[2]  = '{4'b0010, 0, 0, 4};
    vecs[3]  = '{4'b0100, 0, 2, 7};
    vecs[4]  = '{4'b0100, 0, 0, 5};
    vecs[5]  = '{4'b0101, 0, 0, 4};
    vecs[6]  = '{4'b0101, 1, 1, 6};
    vecs[7]  = '{4'b0110, 0, 0, 3};
    vecs[8]  = '{4'b0111, 0, 0, 3};
    vecs[9]  = '{4'b1001, 0, 0, 4};
    vecs[10] = '{4'b1011, 0, 0, 4};
    vecs[11] = '{4'b1010, 2, 0, 6};
    vecs[12] = '{4'b1100, 0, 0, 2};
    vecs[13] = '{4'b0011, 0, 0, 2};
    vecs[14] = '{4'b1000, 0, 0, 2};
    vecs[15] = '{4'b1101, 0, 0, 2};
    vecs[16] = '{4'b1110, 1, 0, 3};

    bus.mem_ready = 1'b0;
    bus.Opcode    = 4'b0000;
    bus.Zero      = 1'b0;

    do_reset(1'b0);

    for (int i = 0; i < 17; i++) begin
      push_instr(vecs[i].op, vecs[i].fw, vecs[i].mw, 0);
      run($sformatf("op%b_fw%0d_mw%0d", vecs[i].op, vecs[i].fw, vecs[i].mw), vecs[i].cycles);
    end

    // HALT holds for 20 cycles regardless of inputs, then reset recovers.
    push_instr(4'b1111, 0, 0, 20);
    run("halt", 0);
    do_reset(1'b1);
    push_instr(4'b1001, 0, 0, 0);
    run("after_halt_addi", 4);

    // Reset while a store is stalled: IDLE with no strobes, then a clean FETCH.
    push(S_FETCH, 1'b1, rnd4(), 1'b0);
    push(S_DECODE, 1'b1, 4'b0101, 1'b0);
    push(S_MEM_ADDR, 1'b1, rnd4(), 1'b0);
    for (int i = 0; i < 3; i++) push(S_MEM_WR, 1'b0, rnd4(), 1'b0);
    run("sw_stalled", 0);
    do_reset(1'b0);
    push_instr(4'b0001, 0, 0, 0);
    run("after_abort_r", 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
